// File: rtl/lb_ram_ctrl.sv
// lb_ram_ctrl: line-buffer controller arbitrating producer writes and consumer reads onto one single-port RAM.
// Optional build macro LB_RAM_CTRL_RR_EN: round-robin arbitration on conflict (default is write-priority).
module lb_ram_ctrl #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 30,
  parameter int LINE_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_wr_valid,
  output logic                  o_wr_ready,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_rd_valid,
  input  logic                  i_rd_ready,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  input  logic                  i_flush,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_ram_cs,
  output logic                  o_ram_we,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_din,
  input  logic [DATA_WIDTH-1:0] i_ram_dout
);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(LINE_WIDTH - 1);
  localparam logic [ADDR_WIDTH:0]   CAP  = (ADDR_WIDTH + 1)'(LINE_WIDTH);
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic wr_req, rd_req, wr_gnt, rd_gnt;
  assign o_count = count;
  assign o_full  = count == CAP;
  assign o_empty = count == '0;
  assign wr_req  = i_wr_valid && !o_full && !i_flush;
  assign rd_req  = !o_empty && (!o_rd_valid || i_rd_ready) && !i_flush;
`ifdef LB_RAM_CTRL_RR_EN
  logic last_rd;
  assign wr_gnt = wr_req && (!rd_req || last_rd);
  // remember which side won most recently so a conflict goes to the other one
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) last_rd <= 1'b1;
    else if (wr_gnt || rd_gnt) last_rd <= rd_gnt;
`else
  assign wr_gnt = wr_req;
`endif
  assign rd_gnt     = rd_req && !wr_gnt;
  assign o_wr_ready = wr_gnt;
  assign o_ram_cs   = wr_gnt || rd_gnt;
  assign o_ram_we   = wr_gnt;
  assign o_ram_addr = wr_gnt ? wr_ptr : rd_gnt ? rd_ptr : '0;
  assign o_ram_din  = wr_gnt ? i_wr_data : '0;
  // pointers, occupancy and the output register; a read grant refills the output word in the same edge it drains
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_rd_valid <= 1'b0;
      o_rd_data  <= '0;
    end else if (i_flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_rd_valid <= 1'b0;
    end else begin
      if (wr_gnt) begin
        wr_ptr <= wr_ptr == LAST ? '0 : wr_ptr + 1'b1;
        count  <= count + 1'b1;
      end
      if (rd_gnt) begin
        rd_ptr     <= rd_ptr == LAST ? '0 : rd_ptr + 1'b1;
        count      <= count - 1'b1;
        o_rd_data  <= i_ram_dout;
        o_rd_valid <= 1'b1;
      end else if (i_rd_ready) o_rd_valid <= 1'b0;
    end
endmodule
